// File: rtl/regfile_master.sv
// Requester-side controller for the register file. Requests are buffered in a small FIFO
// and issued strictly in order as one-cycle rf_wr/rf_rd strobes. Read data is returned on
// a valid/ready response port, with only one read outstanding at a time.
module regfile_master #(
  parameter int unsigned DATA_W     = 20,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LAT     = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_wr,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ADDR_W-1:0]             rsp_addr,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rf_wr,
  output logic                          rf_rd,
  output logic [ADDR_W-1:0]             rf_addr,
  output logic [DATA_W-1:0]             rf_wdata,
  input  logic [DATA_W-1:0]             rf_rdata,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned    PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned    CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  // Index of the last RD_WAIT cycle; unused when RD_LAT is 0.
  localparam logic [1:0]     LAT_LAST = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StSettle,
    StRdWait,
    StRspHold
  } state_e;

  // FIFO storage and bookkeeping
  logic              r_fifo_wr   [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  state_e            r_state;
  state_e            w_state_next;
  state_e            w_next_op;
  logic [1:0]        r_lat_cnt;

  logic              r_rf_wr;
  logic              r_rf_rd;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_rsp_valid;
  logic [ADDR_W-1:0] r_rsp_addr;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_capture;
  logic              w_rsp_done;
  logic              w_head_wr;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_conflict;

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  // Held low during reset so nothing is accepted while the block is being cleared.
  assign req_ready   = reset_n & ~w_full;
  assign w_push      = req_valid & req_ready;
  assign w_head_wr   = r_fifo_wr[r_rptr];
  assign w_head_addr = r_fifo_addr[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];

  // A read right behind a write to the same register must wait one cycle, because the
  // register file commits writes a cycle late. r_rf_wr is only set while in StIssue.
  assign w_conflict  = ~w_head_wr & r_rf_wr & (w_head_addr == r_rf_addr);
  assign w_next_op   = w_empty ? StIdle : (w_conflict ? StSettle : StIssue);

  // FIFO payload write; no reset needed since entries are qualified by r_count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_wr[r_wptr]   <= req_wr;
      r_fifo_addr[r_wptr] <= req_addr;
      r_fifo_data[r_wptr] <= req_wdata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) w_state_next = StIssue;
      end
      StIssue: begin
        if (r_rf_rd) begin
          if (RD_LAT > 0) w_state_next = StRdWait;
          else            w_state_next = StRspHold;
        end else begin
          w_state_next = w_next_op;
        end
      end
      StSettle: begin
        w_state_next = StIssue;
      end
      StRdWait: begin
        if (r_lat_cnt == LAT_LAST) w_state_next = StRspHold;
      end
      StRspHold: begin
        if (rsp_ready) w_state_next = w_next_op;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: pop on entry to StIssue, capture read data on entry to StRspHold
  always_comb begin
    w_pop      = (w_state_next == StIssue);
    w_capture  = (w_state_next == StRspHold) && (r_state != StRspHold);
    w_rsp_done = (r_state == StRspHold) && rsp_ready;
  end

  // Read-latency counter, cleared whenever not waiting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lat_cnt <= '0;
    end else if (r_state == StRdWait) begin
      r_lat_cnt <= r_lat_cnt + 1'b1;
    end else begin
      r_lat_cnt <= '0;
    end
  end

  // Registered register-file drive; address and data hold between strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rf_wr    <= 1'b0;
      r_rf_rd    <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_wr <= w_pop & w_head_wr;
      r_rf_rd <= w_pop & ~w_head_wr;
      if (w_pop) r_rf_addr <= w_head_addr;
      if (w_pop && w_head_wr) r_rf_wdata <= w_head_data;
    end
  end

  // Response holding register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_rdata <= '0;
    end else if (w_capture) begin
      r_rsp_valid <= 1'b1;
      r_rsp_addr  <= r_rf_addr;
      r_rsp_rdata <= rf_rdata;
    end else if (w_rsp_done) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rf_wr      = r_rf_wr;
  assign rf_rd      = r_rf_rd;
  assign rf_addr    = r_rf_addr;
  assign rf_wdata   = r_rf_wdata;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_addr   = r_rsp_addr;
  assign rsp_rdata  = r_rsp_rdata;
  assign busy       = ~w_empty | (r_state != StIdle);
  assign fifo_count = r_count;

endmodule

// File: tb/tb_regfile_master.sv
// Directed bench for regfile_master: one instance with RD_LAT=0 and one with RD_LAT=2,
// each attached to a register file model that commits writes one cycle late.
module tb_regfile_master;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // RD_LAT = 0 instance signals
  logic        req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rf_wr, rf_rd, busy;
  logic [3:0]  req_addr, rsp_addr, rf_addr;
  logic [19:0] req_wdata, rsp_rdata, rf_wdata, rf_rdata;
  logic [2:0]  fifo_count;

  // RD_LAT = 2 instance signals
  logic        b_req_valid, b_req_ready, b_req_wr, b_rsp_valid, b_rsp_ready;
  logic        b_rf_wr, b_rf_rd, b_busy;
  logic [3:0]  b_req_addr, b_rsp_addr, b_rf_addr;
  logic [19:0] b_req_wdata, b_rsp_rdata, b_rf_wdata, b_rf_rdata;
  logic [2:0]  b_fifo_count;

  regfile_master #(.DATA_W(20), .ADDR_W(4), .FIFO_DEPTH(4), .RD_LAT(0)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_rdata(rsp_rdata),
    .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .busy(busy), .fifo_count(fifo_count)
  );

  regfile_master #(.DATA_W(20), .ADDR_W(4), .FIFO_DEPTH(4), .RD_LAT(2)) u_dut_lat2 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_addr(b_rsp_addr),
    .rsp_rdata(b_rsp_rdata),
    .rf_wr(b_rf_wr), .rf_rd(b_rf_rd), .rf_addr(b_rf_addr), .rf_wdata(b_rf_wdata),
    .rf_rdata(b_rf_rdata), .busy(b_busy), .fifo_count(b_fifo_count)
  );

  // Register file models: register i starts at 0x10000+i, writes land one cycle late
  logic [19:0] mem0 [16];
  logic [19:0] mem1 [16];
  logic        pend0_v, pend1_v;
  logic [3:0]  pend0_a, pend1_a;
  logic [19:0] pend0_d, pend1_d, rd1_d1, rd1_d2;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) mem0[i] <= 20'h10000 + 20'(i);
      pend0_v <= 1'b0;
      pend0_a <= '0;
      pend0_d <= '0;
    end else begin
      if (pend0_v) mem0[pend0_a] <= pend0_d;
      pend0_v <= rf_wr;
      pend0_a <= rf_addr;
      pend0_d <= rf_wdata;
    end
  end
  assign rf_rdata = mem0[rf_addr];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) mem1[i] <= 20'h10000 + 20'(i);
      pend1_v <= 1'b0;
      pend1_a <= '0;
      pend1_d <= '0;
      rd1_d1  <= '0;
      rd1_d2  <= '0;
    end else begin
      if (pend1_v) mem1[pend1_a] <= pend1_d;
      pend1_v <= b_rf_wr;
      pend1_a <= b_rf_addr;
      pend1_d <= b_rf_wdata;
      rd1_d1  <= mem1[b_rf_addr];
      rd1_d2  <= rd1_d1;
    end
  end
  assign b_rf_rdata = rd1_d2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || b_busy) && n < 60) begin
      step();
      n++;
    end
    check(tag, 32'(busy | b_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    req_valid   = 1'b0; req_wr   = 1'b0; req_addr   = '0; req_wdata   = '0; rsp_ready   = 1'b1;
    b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;

    // Reset state
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_outputs", 32'({rf_wr, rf_rd, rsp_valid, busy}), 32'd0);
    #10;
    reset_n = 1'b1;
    #1;
    check("rel_req_ready", 32'(req_ready), 32'd1);
    step();

    // Write then read of the same register: settle bubble before the read
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd3; req_wdata = 20'hABCDE;
    step();
    req_wr = 1'b0;
    step();
    req_valid = 1'b0;
    check("t2_wr", 32'(rf_wr), 32'd1);
    check("t2_wr_addr", 32'(rf_addr), 32'd3);
    check("t2_wr_data", 32'(rf_wdata), 32'hABCDE);
    step();
    check("t2_settle", 32'({rf_wr, rf_rd}), 32'd0);
    step();
    check("t2_rd", 32'(rf_rd), 32'd1);
    check("t2_rd_addr", 32'(rf_addr), 32'd3);
    step();
    check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t2_rsp_rdata", 32'(rsp_rdata), 32'hABCDE);
    check("t2_rsp_addr", 32'(rsp_addr), 32'd3);
    wait_idle("t2_idle");

    // Back-to-back write burst: one strobe per cycle
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'(i); req_wdata = 20'(32'h1000 + i);
      step();
      if (i > 0) begin
        check("t4_wr", 32'(rf_wr), 32'd1);
        check("t4_addr", 32'(rf_addr), 32'(i - 1));
      end
    end
    req_valid = 1'b0;
    step();
    check("t4_wr_last", 32'(rf_wr), 32'd1);
    check("t4_addr_last", 32'(rf_addr), 32'd3);
    check("t4_data_last", 32'(rf_wdata), 32'h1003);
    step();
    check("t4_wr_end", 32'(rf_wr), 32'd0);
    wait_idle("t4_idle");

    // RD_LAT=2: write then read of another register, no bubble, response 2 cycles later
    b_req_valid = 1'b1; b_req_wr = 1'b1; b_req_addr = 4'd2; b_req_wdata = 20'h55555;
    step();
    b_req_wr = 1'b0; b_req_addr = 4'd7;
    step();
    b_req_valid = 1'b0;
    check("t6_wr", 32'(b_rf_wr), 32'd1);
    step();
    check("t6_rd_no_settle", 32'(b_rf_rd), 32'd1);
    check("t6_rd_addr", 32'(b_rf_addr), 32'd7);
    step();
    check("t6_wait1", 32'(b_rsp_valid), 32'd0);
    step();
    check("t6_wait2", 32'(b_rsp_valid), 32'd0);
    step();
    check("t6_rsp_valid", 32'(b_rsp_valid), 32'd1);
    check("t6_rsp_rdata", 32'(b_rsp_rdata), 32'h10007);
    check("t6_rsp_addr", 32'(b_rsp_addr), 32'd7);
    wait_idle("t6_idle");

    // Full FIFO under response backpressure
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'(8 + i);
      step();
    end
    check("t3_count_full", 32'(fifo_count), 32'd4);
    check("t3_ready_full", 32'(req_ready), 32'd0);
    req_addr = 4'd13;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_hold_count", 32'(fifo_count), 32'd4);
      check("t3_hold_ready", 32'(req_ready), 32'd0);
      check("t3_hold_rsp_addr", 32'(rsp_addr), 32'd8);
    end
    rsp_ready = 1'b1;
    step();
    check("t3_pop_count", 32'(fifo_count), 32'd3);
    check("t3_pop_rd", 32'(rf_rd), 32'd1);
    check("t3_pop_addr", 32'(rf_addr), 32'd9);
    check("t3_pop_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("t3_push_count", 32'(fifo_count), 32'd4);
    check("t3_rsp2_valid", 32'(rsp_valid), 32'd1);
    check("t3_rsp2_addr", 32'(rsp_addr), 32'd9);
    check("t3_rsp2_rdata", 32'(rsp_rdata), 32'h10009);
    wait_idle("t3_idle");

    // Response backpressure: response stable, queued write not issued
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd5;
    step();
    req_wr = 1'b1; req_addr = 4'd6; req_wdata = 20'h0BEEF;
    step();
    req_valid = 1'b0;
    step();
    check("t5_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t5_rsp_rdata", 32'(rsp_rdata), 32'h10005);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5_no_strobe", 32'({rf_wr, rf_rd}), 32'd0);
      check("t5_rdata_stable", 32'(rsp_rdata), 32'h10005);
    end
    rsp_ready = 1'b1;
    step();
    check("t5_rsp_done", 32'(rsp_valid), 32'd0);
    check("t5_wr_after", 32'(rf_wr), 32'd1);
    check("t5_wr_addr", 32'(rf_addr), 32'd6);
    wait_idle("t5_idle");

    // Asynchronous reset while a response is held and requests are queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'(5 + i);
      step();
    end
    req_valid = 1'b0;
    step();
    check("t1_pre_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_pre_count", 32'(fifo_count), 32'd2);
    #3;
    reset_n = 1'b0;
    #1;
    check("t1_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t1_count", 32'(fifo_count), 32'd0);
    check("t1_strobes", 32'({rf_wr, rf_rd, busy}), 32'd0);
    check("t1_ready_in_reset", 32'(req_ready), 32'd0);
    #10;
    reset_n = 1'b1;
    step();
    check("t1_ready_after", 32'(req_ready), 32'd1);
    check("t1_idle_after", 32'({rsp_valid, busy}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
